// File: rtl/pipe_pkg.sv
// Shared types for the pipeline: ALU control codes, the EX->MEM bundle and
// the EX->MEM stage-register state encoding.
package pipe_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LUI = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_ctl_t;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [RW_DEF-1:0] rn;
    logic [DW_DEF-1:0] alu;
    logic [DW_DEF-1:0] b;
  } em_bundle_t;

  localparam int EM_W = $bits(em_bundle_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } em_state_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry holding register with synchronous load and clear; clear wins.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int W = EM_W
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] slot_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      slot_q <= '0;
    end else if (clear) begin
      slot_q <= '0;
    end else if (load) begin
      slot_q <= d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/pipe_emreg.sv
// EX->MEM stage register with valid/ready handshake, flush and a saturating
// back-pressure counter. Define EMREG_SKID_EN for a registered e_ready plus skid slot.
//
// state    | meaning
// ST_EMPTY | no entry held; m_valid=0
// ST_FULL  | main entry presented on m*
// ST_SKID  | main entry stalled and a second entry parked in the skid slot
module pipe_emreg
  import pipe_pkg::*;
#(
  parameter int DW          = 32,
  parameter int RW          = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   e_valid,
  output logic                   e_ready,
  input  logic                   ewreg,
  input  logic                   em2reg,
  input  logic                   ewmem,
  input  logic [RW-1:0]          ern,
  input  logic [DW-1:0]          ealu,
  input  logic [DW-1:0]          eb,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   mwreg,
  output logic                   mm2reg,
  output logic                   mwmem,
  output logic [RW-1:0]          mrn,
  output logic [DW-1:0]          malu,
  output logic [DW-1:0]          mb,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int BW = 3 + RW + 2 * DW;

  em_state_t              state_q, state_d;
  logic [BW-1:0]          main_q, main_d;
  logic [BW-1:0]          in_bus;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   valid_int;
  logic                   ready_int;
  logic                   accept;

  assign in_bus    = {ewreg, em2reg, ewmem, ern, ealu, eb};
  assign valid_int = (state_q != ST_EMPTY);
  assign accept    = e_valid && ready_int;

`ifdef EMREG_SKID_EN
  logic          e_ready_q;
  logic [BW-1:0] skid_q;
  logic          skid_load;

  pipe_skid_slot #(.W(BW)) u_skid (
    .clk   (clk),
    .clrn  (clrn),
    .load  (skid_load),
    .clear (flush),
    .d     (in_bus),
    .q     (skid_q)
  );

  // Ready is known a cycle ahead: it only drops while the skid slot is occupied.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) e_ready_q <= 1'b1;
    else       e_ready_q <= (state_d != ST_SKID);
  end

  assign ready_int = e_ready_q;
`else
  assign ready_int = !valid_int || m_ready;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef EMREG_SKID_EN
    skid_load = 1'b0;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            main_d  = in_bus;
          end
        end
        ST_FULL: begin
          if (accept) begin
            if (m_ready) begin
              main_d = in_bus;
            end
`ifdef EMREG_SKID_EN
            else begin
              state_d   = ST_SKID;
              skid_load = 1'b1;
            end
`endif
          end else if (m_ready) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef EMREG_SKID_EN
        ST_SKID: begin
          if (m_ready) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (valid_int && !m_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      stall_q <= stall_d;
    end
  end

  assign e_ready   = ready_int;
  assign m_valid   = valid_int;
  assign mwreg     = valid_int & main_q[BW-1];
  assign mm2reg    = valid_int & main_q[BW-2];
  assign mwmem     = valid_int & main_q[BW-3];
  assign mrn       = main_q[2*DW +: RW];
  assign malu      = main_q[DW +: DW];
  assign mb        = main_q[DW-1:0];
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_emreg.sv
// Directed bench for pipe_emreg (4-bit stall counter); adapts to EMREG_SKID_EN.
module tb_pipe_emreg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          clrn;
  logic          e_valid, e_ready, ewreg, em2reg, ewmem, flush;
  logic [RW-1:0] ern;
  logic [DW-1:0] ealu, eb;
  logic          m_valid, m_ready, mwreg, mm2reg, mwmem;
  logic [RW-1:0] mrn;
  logic [DW-1:0] malu, mb;
  logic [SW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_emreg #(.DW(DW), .RW(RW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .clrn(clrn), .e_valid(e_valid), .e_ready(e_ready),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern),
    .ealu(ealu), .eb(eb), .flush(flush), .m_valid(m_valid),
    .m_ready(m_ready), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mrn(mrn), .malu(malu), .mb(mb), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    clrn = 1'b0; e_valid = 1'b0; ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
    ern = '0; ealu = '0; eb = '0; flush = 1'b0; m_ready = 1'b0;
    #2;
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_stall", 64'(stall_cnt), 64'd0);
    check_eq("rst_e_ready", 64'(e_ready), 64'd1);
    @(negedge clk);
    clrn = 1'b1;

    // back-to-back stream
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      e_valid = 1'b1; ewreg = 1'b1; ern = RW'(i); ealu = DW'(i);
      tick();
      check_eq("stream_malu", 64'(malu), 64'(i));
      check_eq("stream_valid", 64'(m_valid), 64'd1);
      check_eq("stream_mrn", 64'(mrn), 64'(i));
    end
    e_valid = 1'b0;
    tick();
    check_eq("stream_drained", 64'(m_valid), 64'd0);
    check_eq("stream_no_stall", 64'(stall_cnt), 64'd0);

    // stall with entry held
    e_valid = 1'b1; ewreg = 1'b0; ewmem = 1'b1; ern = 5'd7;
    ealu = 32'hDEADBEEF; eb = 32'h1234; m_ready = 1'b0;
    tick();
    check_eq("stall_load_malu", 64'(malu), 64'hDEADBEEF);
    check_eq("stall_load_mwmem", 64'(mwmem), 64'd1);
    check_eq("stall_load_cnt", 64'(stall_cnt), 64'd0);
`ifdef EMREG_SKID_EN
    ealu = 32'hCAFE0001; eb = 32'h5678;
`else
    e_valid = 1'b0;
`endif
    for (int k = 1; k <= 3; k++) begin
      tick();
      e_valid = 1'b0;
      check_eq("stall_malu_hold", 64'(malu), 64'hDEADBEEF);
      check_eq("stall_mb_hold", 64'(mb), 64'h1234);
      check_eq("stall_cnt", 64'(stall_cnt), 64'(k));
      check_eq("stall_e_ready", 64'(e_ready), 64'd0);
    end
    m_ready = 1'b1;
    tick();
`ifdef EMREG_SKID_EN
    check_eq("skid_to_main_malu", 64'(malu), 64'hCAFE0001);
    check_eq("skid_to_main_valid", 64'(m_valid), 64'd1);
    check_eq("skid_e_ready_back", 64'(e_ready), 64'd1);
    tick();
`endif
    check_eq("stall_release_valid", 64'(m_valid), 64'd0);
    check_eq("stall_release_cnt", 64'(stall_cnt), 64'd3);

    // flush beats a same-cycle accept
    e_valid = 1'b1; ewreg = 1'b1; ewmem = 1'b0; ealu = 32'h55; m_ready = 1'b0;
    tick();
    check_eq("flush_pre_valid", 64'(m_valid), 64'd1);
    flush = 1'b1; ewmem = 1'b1; ealu = 32'h66; m_ready = 1'b1;
    tick();
    flush = 1'b0; e_valid = 1'b0;
    check_eq("flush_valid", 64'(m_valid), 64'd0);
    check_eq("flush_mwmem", 64'(mwmem), 64'd0);
    check_eq("flush_mwreg", 64'(mwreg), 64'd0);
    check_eq("flush_malu_kept", 64'(malu), 64'h55);
    check_eq("flush_e_ready", 64'(e_ready), 64'd1);
    check_eq("flush_cnt_kept", 64'(stall_cnt), 64'd3);
    tick();
    check_eq("flush_stays_empty", 64'(m_valid), 64'd0);

    // simultaneous drain and accept
    m_ready = 1'b1; e_valid = 1'b1; ewreg = 1'b1; ewmem = 1'b0; ealu = 32'hA1;
    tick();
    check_eq("replace_first", 64'(malu), 64'hA1);
    ealu = 32'hA2;
    tick();
    check_eq("replace_second", 64'(malu), 64'hA2);
    check_eq("replace_valid", 64'(m_valid), 64'd1);
    e_valid = 1'b0;
    tick();
    check_eq("replace_drained", 64'(m_valid), 64'd0);
    check_eq("replace_cnt", 64'(stall_cnt), 64'd3);

    // counter saturation
    e_valid = 1'b1; ewreg = 1'b1; ealu = 32'h77; m_ready = 1'b0;
    tick();
    e_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_cnt = (3 + k > 15) ? 15 : 3 + k;
      check_eq("sat_cnt", 64'(stall_cnt), 64'(exp_cnt));
    end
    check_eq("sat_malu", 64'(malu), 64'h77);
    check_eq("sat_mwreg", 64'(mwreg), 64'd1);

    // asynchronous reset away from any edge
    #2;
    clrn = 1'b0;
    #1;
    check_eq("arst_valid", 64'(m_valid), 64'd0);
    check_eq("arst_mwreg", 64'(mwreg), 64'd0);
    check_eq("arst_malu", 64'(malu), 64'd0);
    check_eq("arst_cnt", 64'(stall_cnt), 64'd0);
    check_eq("arst_e_ready", 64'(e_ready), 64'd1);
    @(negedge clk);
    clrn = 1'b1; m_ready = 1'b1;
    tick();
    check_eq("arst_after_valid", 64'(m_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
